// File: rtl/mem_access_unit.sv
// Load/store unit: aligns requests onto a full-width memory bus and sign/zero-extends loads.
// Handles one request at a time: IDLE -> ISSUE -> WAIT -> RESP, with a read timeout and error reporting.
module mem_access_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_byteen,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [1:0]         lat_size;
    logic               lat_signed;
    logic [OFF_W-1:0]   lat_off;

    logic [OFF_W-1:0]   req_off_c;
    logic               illegal_c;
    logic               misalign_c;
    logic [BE_W-1:0]    be_base_c;
    logic [DATA_W-1:0]  shifted_c;
    logic [DATA_W-1:0]  mask_c;
    logic [DATA_W-1:0]  load_data_c;
    logic               top_bit_c;
    int unsigned        nbits_c;

    // Request decode: byte-lane pattern before shifting, alignment and size legality.
    always_comb begin : req_decode
        req_off_c  = req_addr[OFF_W-1:0];
        illegal_c  = (req_size == 2'b11) && (DATA_W == 32);
        misalign_c = 1'b0;
        be_base_c  = '1;
        case (req_size)
            2'b00: be_base_c = BE_W'(1);
            2'b01: begin
                be_base_c  = BE_W'(3);
                misalign_c = req_off_c[0];
            end
            2'b10: begin
                be_base_c  = BE_W'(4'hF);
                misalign_c = |req_off_c[1:0];
            end
            default: misalign_c = |req_off_c;
        endcase
    end

    // Load extraction; a full-width access leaves the line untouched.
    always_comb begin : load_extract
        shifted_c = mem_rdata >> {lat_off, 3'b000};
        nbits_c   = 32'd8 << lat_size;
        if (nbits_c >= DATA_W) begin
            mask_c    = '1;
            top_bit_c = 1'b0;
        end else begin
            mask_c    = (DATA_W'(1) << nbits_c) - DATA_W'(1);
            top_bit_c = shifted_c[IDX_W'(nbits_c - 32'd1)];
        end
        load_data_c = (shifted_c & mask_c) | ((lat_signed && top_bit_c) ? ~mask_c : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_off    <= '0;
            req_ready  <= 1'b1;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_off    <= req_off_c;
                        req_ready  <= 1'b0;
                        if (illegal_c || misalign_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_err   <= illegal_c ? ERR_ILLEGAL : ERR_MISALIGN;
                        end else begin
                            state      <= ISSUE;
                            mem_en     <= 1'b1;
                            mem_we     <= req_we;
                            mem_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_byteen <= be_base_c << req_off_c;
                            mem_wdata  <= req_wdata << {req_off_c, 3'b000};
                        end
                    end
                end
                ISSUE: begin
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_addr   <= '0;
                    mem_byteen <= '0;
                    mem_wdata  <= '0;
                    if (lat_we) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_OK;
                    end else begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= load_data_c;
                        rsp_err   <= ERR_OK;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
